// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory server
// Purpose: FSM state encoding, instruction width and fault word shared with decode.
// Ports: none (package).
package imem_pkg;

  localparam int IW = 9;
  localparam logic [IW-1:0] NOP_INSTR = 9'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_t;

endpackage

// File: rtl/instr_mem_server_if.sv
// rtl/instr_mem_server_if.sv - load and fetch bus of the instruction memory server
// Purpose: groups the program-load stream, the fetch request/response and status.
// Ports (master drives): load_start, load_valid, load_data, load_done, fetch_req,
//   instr_addr. Ports (slave drives): instr_out, instr_valid, addr_fault,
//   load_count, load_overflow, running.
interface instr_mem_server_if #(
  parameter int IW    = imem_pkg::IW,
  parameter int DEPTH = 256
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          load_start;
  logic          load_valid;
  logic [IW-1:0] load_data;
  logic          load_done;
  logic          fetch_req;
  logic [15:0]   instr_addr;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic          addr_fault;
  logic [CW-1:0] load_count;
  logic          load_overflow;
  logic          running;

  modport master (
    output load_start, load_valid, load_data, load_done, fetch_req, instr_addr,
    input  instr_out, instr_valid, addr_fault, load_count, load_overflow, running
  );

  modport slave (
    input  load_start, load_valid, load_data, load_done, fetch_req, instr_addr,
    output instr_out, instr_valid, addr_fault, load_count, load_overflow, running
  );
endinterface

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - DEPTH x IW program store, one write port, synchronous read
// Purpose: holds the program; the array itself is never reset.
// Ports: clk, rst (async, clears read register only), we/waddr/wdata write port,
//   re/raddr read request, rdata registered read data (held while re is low).
module imem_ram #(
  parameter int IW    = imem_pkg::IW,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only updates on a request so the last fetched word persists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_server.sv
// rtl/instr_mem_server.sv - instruction memory responder with sequential program load
// Purpose: IDLE/LOAD/RUN control, load counter with sticky overflow, 1-cycle fetch
//   with out-of-range fault returning NOP_INSTR.
// Ports: CLK, reset_ctrl (async active-high), bus (instr_mem_server_if.slave).
module instr_mem_server
  import imem_pkg::*;
#(
  parameter int              IW        = imem_pkg::IW,
  parameter int              DEPTH     = 256,
  parameter logic [IW-1:0]   NOP_INSTR = imem_pkg::NOP_INSTR
) (
  input  logic              CLK,
  input  logic              reset_ctrl,
  instr_mem_server_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  imem_state_t   state, state_next;
  logic [CW-1:0] load_count;
  logic          load_overflow;
  logic          full;
  logic          wr_en, ovf_set, fetch_acc, out_of_range;
  logic          valid_q, fault_q, nop_q;
  logic [IW-1:0] ram_rdata;

  assign full = (load_count == CW'(DEPTH));
  // Full 16-bit compare so addresses beyond DEPTH fault instead of aliasing.
  assign out_of_range = ({1'b0, bus.instr_addr} >= 17'(load_count));

  always_ff @(posedge CLK or posedge reset_ctrl) begin
    if (reset_ctrl) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.load_start) state_next = LOAD;
      LOAD:    if (bus.load_start) state_next = LOAD;
               else if (bus.load_done) state_next = RUN;
      RUN:     if (bus.load_start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // load_start always wins: it drops any same-cycle load word or fetch.
  always_comb begin
    wr_en     = 1'b0;
    ovf_set   = 1'b0;
    fetch_acc = 1'b0;
    case (state)
      LOAD: begin
        wr_en   = !bus.load_start && bus.load_valid && !full;
        ovf_set = !bus.load_start && bus.load_valid && full;
      end
      RUN:     fetch_acc = !bus.load_start && bus.fetch_req;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge reset_ctrl) begin
    if (reset_ctrl) begin
      load_count    <= '0;
      load_overflow <= 1'b0;
    end else if (bus.load_start) begin
      load_count    <= '0;
      load_overflow <= 1'b0;
    end else begin
      if (wr_en)   load_count    <= load_count + CW'(1);
      if (ovf_set) load_overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset_ctrl) begin
    if (reset_ctrl) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      nop_q   <= 1'b0;
    end else begin
      valid_q <= fetch_acc;
      fault_q <= fetch_acc && out_of_range;
      if (fetch_acc) nop_q <= out_of_range;
    end
  end

  imem_ram #(.IW(IW), .DEPTH(DEPTH)) u_ram (
    .clk   (CLK),
    .rst   (reset_ctrl),
    .we    (wr_en),
    .waddr (load_count[AW-1:0]),
    .wdata (bus.load_data),
    .re    (fetch_acc),
    .raddr (bus.instr_addr[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.instr_out     = nop_q ? NOP_INSTR : ram_rdata;
  assign bus.instr_valid   = valid_q;
  assign bus.addr_fault    = fault_q;
  assign bus.load_count    = load_count;
  assign bus.load_overflow = load_overflow;
  assign bus.running       = (state == RUN);

endmodule

// File: tb/tb_instr_mem_server.sv
// tb/tb_instr_mem_server.sv - self-checking bench for instr_mem_server
module tb_instr_mem_server;

  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

  logic        CLK = 1'b0;
  logic        reset_ctrl;
  logic        load_start, load_valid, load_done, fetch_req;
  logic [8:0]  load_data;
  logic [15:0] instr_addr;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  instr_mem_server_if #(.IW(9), .DEPTH(256)) bi ();
  instr_mem_server_if #(.IW(9), .DEPTH(4))   si ();

  assign bi.load_start = load_start;  assign si.load_start = load_start;
  assign bi.load_valid = load_valid;  assign si.load_valid = load_valid;
  assign bi.load_data  = load_data;   assign si.load_data  = load_data;
  assign bi.load_done  = load_done;   assign si.load_done  = load_done;
  assign bi.fetch_req  = fetch_req;   assign si.fetch_req  = fetch_req;
  assign bi.instr_addr = instr_addr;  assign si.instr_addr = instr_addr;

  instr_mem_server #(.IW(9), .DEPTH(256), .NOP_INSTR(9'h000)) dut_b (
    .CLK(CLK), .reset_ctrl(reset_ctrl), .bus(bi.slave));
  instr_mem_server #(.IW(9), .DEPTH(4), .NOP_INSTR(9'h000)) dut_s (
    .CLK(CLK), .reset_ctrl(reset_ctrl), .bus(si.slave));

  // Reference model: per instance, the loaded program as a list plus its length.
  int         depth [2] = '{256, 4};
  int         mode  [2];
  int         pcnt  [2];
  logic       ovf   [2];
  logic [8:0] pmem  [2][256];
  logic [8:0] exp_out   [2];
  logic       exp_valid [2];
  logic       exp_fault [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = M_IDLE; pcnt[k] = 0; ovf[k] = 1'b0;
      exp_out[k] = '0; exp_valid[k] = 1'b0; exp_fault[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      exp_valid[k] = 1'b0;
      exp_fault[k] = 1'b0;
      if (load_start) begin
        mode[k] = M_LOAD; pcnt[k] = 0; ovf[k] = 1'b0;
      end else if (mode[k] == M_LOAD) begin
        if (load_valid) begin
          if (pcnt[k] < depth[k]) begin pmem[k][pcnt[k]] = load_data; pcnt[k]++; end
          else ovf[k] = 1'b1;
        end
        if (load_done) mode[k] = M_RUN;
      end else if (mode[k] == M_RUN && fetch_req) begin
        exp_valid[k] = 1'b1;
        if (int'(instr_addr) < pcnt[k]) exp_out[k] = pmem[k][instr_addr];
        else begin exp_out[k] = 9'h000; exp_fault[k] = 1'b1; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".b.out"},   bi.instr_out,     exp_out[0]);
    chk({tag, ".b.valid"}, bi.instr_valid,   exp_valid[0]);
    chk({tag, ".b.fault"}, bi.addr_fault,    exp_fault[0]);
    chk({tag, ".b.cnt"},   bi.load_count,    pcnt[0]);
    chk({tag, ".b.ovf"},   bi.load_overflow, ovf[0]);
    chk({tag, ".b.run"},   bi.running,       mode[0] == M_RUN);
    chk({tag, ".s.out"},   si.instr_out,     exp_out[1]);
    chk({tag, ".s.valid"}, si.instr_valid,   exp_valid[1]);
    chk({tag, ".s.fault"}, si.addr_fault,    exp_fault[1]);
    chk({tag, ".s.cnt"},   si.load_count,    pcnt[1]);
    chk({tag, ".s.ovf"},   si.load_overflow, ovf[1]);
    chk({tag, ".s.run"},   si.running,       mode[1] == M_RUN);
  endtask

  task automatic cycle(input string tag);
    @(posedge CLK);
    if (reset_ctrl) model_reset();
    else            model_step();
    #1;
    check_all(tag);
  endtask

  task automatic quiet();
    load_start = 0; load_valid = 0; load_done = 0; fetch_req = 0;
    load_data = '0; instr_addr = '0;
  endtask

  task automatic load_word(input logic [8:0] w, input logic done, input string tag);
    load_valid = 1; load_data = w; load_done = done;
    cycle(tag);
    load_valid = 0; load_done = 0;
  endtask

  task automatic fetch(input logic [15:0] a, input string tag);
    fetch_req = 1; instr_addr = a;
    cycle(tag);
  endtask

  initial begin
    quiet();
    reset_ctrl = 1;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    check_all("reset");
    reset_ctrl = 0;

    // Fetch requests in IDLE and during LOAD must never respond.
    fetch_req = 1; instr_addr = 16'd0;
    cycle("gate_idle"); cycle("gate_idle2");
    load_start = 1; cycle("start"); load_start = 0;
    load_word(9'h011, 0, "ld0"); load_word(9'h022, 0, "ld1");
    load_word(9'h033, 0, "ld2"); load_word(9'h044, 0, "ld3");
    fetch_req = 1; load_done = 1; cycle("done"); load_done = 0;

    fetch(16'd0, "f0"); chk("basic_f0", bi.instr_out, 9'h011);
    fetch(16'd1, "f1"); chk("basic_f1", bi.instr_out, 9'h022);
    fetch(16'd2, "f2"); chk("basic_f2", bi.instr_out, 9'h033);
    fetch(16'd3, "f3"); chk("basic_f3", bi.instr_out, 9'h044);
    chk("basic_cnt", bi.load_count, 4);

    fetch(16'd4, "oor4");      chk("oor4_fault", bi.addr_fault, 1'b1);
    fetch(16'h0100, "oor100"); chk("oor100_s_fault", si.addr_fault, 1'b1);
    fetch(16'd2, "inr2");      chk("inr2_out", bi.instr_out, 9'h033);
    fetch_req = 0; cycle("hold"); cycle("hold2");

    // Overflow on the DEPTH=4 instance.
    load_start = 1; cycle("ovf_start"); load_start = 0;
    for (int i = 0; i < 6; i++) load_word(9'h0A0 + 9'(i), 0, "ovf_ld");
    chk("ovf_s_cnt", si.load_count, 4);
    chk("ovf_s_flag", si.load_overflow, 1'b1);
    load_done = 1; cycle("ovf_done"); load_done = 0;
    fetch(16'd3, "ovf_f3"); chk("ovf_s_f3", si.instr_out, 9'h0A3);
    fetch(16'd5, "ovf_f5");

    // load_valid together with load_done: word counted.
    fetch_req = 0; load_start = 1; cycle("sim_start"); load_start = 0;
    load_word(9'h0AA, 0, "sim0"); load_word(9'h0BB, 0, "sim1");
    load_word(9'h1FF, 1, "sim2");
    chk("sim_cnt", bi.load_count, 3);
    fetch(16'd2, "sim_f2"); chk("sim_f2_out", bi.instr_out, 9'h1FF);

    // load_start with fetch_req in RUN drops the fetch.
    fetch_req = 1; instr_addr = 16'd0; load_start = 1;
    cycle("drop"); load_start = 0;
    chk("drop_valid", bi.instr_valid, 1'b0);
    chk("drop_cnt", bi.load_count, 0);

    // Asynchronous reset in the middle of a load.
    fetch_req = 0;
    load_word(9'h055, 0, "rst_ld0"); load_word(9'h066, 0, "rst_ld1");
    #3 reset_ctrl = 1;
    #1 model_reset(); check_all("async_rst");
    cycle("rst_hold");
    reset_ctrl = 0;
    load_start = 1; cycle("empty_start"); load_start = 0;
    load_done = 1; cycle("empty_done"); load_done = 0;
    fetch(16'd0, "empty_f0"); chk("empty_fault", bi.addr_fault, 1'b1);
    fetch(16'd1, "empty_f1");

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      load_start = ($urandom % 40) == 0;
      load_valid = $urandom % 2;
      load_data  = 9'($urandom);
      load_done  = ($urandom % 25) == 0;
      fetch_req  = ($urandom % 4) != 0;
      instr_addr = (($urandom % 8) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_mem_server.md
Name: instr_mem_server

Overview:
- Instruction-memory responder at the far end of the fetch interface. Receives the 16-bit fetch address from the instruction fetch stage and returns the addressed instruction word one cycle later.
- Also owns the program-load path: a testbench or loader streams the program in sequentially before execution starts.
- Sits between the fetch stage and the decode stage; it is the only holder of program storage.

Parameters:
- IW, 9, instruction word width in bits.
- DEPTH, 256, number of instruction words stored (power of two, ≤ 65536).
- NOP_INSTR, 9'h000, word returned on a faulting fetch.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- reset_ctrl  in  1  asynchronous, active-high reset.
- load_start  in  1  begin (or restart) a program load.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  IW  next sequential instruction word.
- load_done  in  1  program load complete; enter run mode.
- fetch_req  in  1  fetch request qualifier.
- instr_addr  in  16  fetch address from the fetch stage.
- instr_out  out  IW  fetched instruction.
- instr_valid  out  1  instr_out valid this cycle.
- addr_fault  out  1  the fetch being returned was out of range.
- load_count  out  $clog2(DEPTH)+1  number of words loaded.
- load_overflow  out  1  sticky flag: a load was attempted past DEPTH.
- running  out  1  high in the RUN state.

Behaviour:
- FSM states: IDLE, LOAD, RUN.
- Reset (asynchronous, any time, including mid-load or mid-fetch):
  - state = IDLE.
  - instr_out = 0, instr_valid = 0, addr_fault = 0, load_count = 0, load_overflow = 0, running = 0.
  - Memory contents are not cleared. Because load_count = 0, nothing stale is reachable without a fresh load.
- IDLE:
  - load_start → LOAD, load_count = 0, load_overflow = 0.
  - All other inputs ignored.
- LOAD:
  - Each cycle with load_valid and load_count < DEPTH: mem[load_count] = load_data, then load_count += 1.
  - load_valid with load_count == DEPTH: no write, no increment; load_overflow set (sticky until the next load_start or reset).
  - load_done → RUN next cycle. If load_valid is asserted in the same cycle, the word is written first; that word is counted.
  - load_start while in LOAD restarts the load: load_count = 0, load_overflow cleared, load_valid in that cycle ignored.
- RUN:
  - fetch_req sampled each cycle. Latency is exactly 1 cycle; back-to-back requests are accepted every cycle with no bubbles.
  - Cycle after a request with instr_addr < load_count: instr_out = mem[instr_addr], instr_valid = 1, addr_fault = 0.
  - Cycle after a request with instr_addr ≥ load_count (this includes any instr_addr ≥ DEPTH, with the full 16-bit compare): instr_out = NOP_INSTR, instr_valid = 1, addr_fault = 1.
  - No request: instr_valid = 0, addr_fault = 0, instr_out holds its previous value.
  - load_start in RUN → LOAD, load_count = 0. A fetch_req in that same cycle is dropped (instr_valid = 0 next cycle).
  - load_valid and load_done are ignored in RUN.
- fetch_req outside RUN: never produces instr_valid.
- running = (state == RUN), registered with state.
- Width rule: the address compare is an unsigned 16-bit comparison against zero-extended load_count. Only the low $clog2(DEPTH) bits index memory.

Decomposition:
- Shared package imem_pkg holds:
  - state enum imem_state_t {IDLE, LOAD, RUN}.
  - NOP_INSTR default.
  - Instruction-width constant IW, shared with decode.
- One natural sub-module: imem_ram, a single-port-write, synchronous-read array (DEPTH × IW). Write enable and address are driven by the load logic; the read address comes from instr_addr. The FSM, counter, fault compare and output registers stay in instr_mem_server.

Test Plan:
- Basic load and fetch: reset; load_start; load 4 words 9'h011, 9'h022, 9'h033, 9'h044; load_done; fetch addresses 0, 1, 2, 3 on consecutive cycles → instr_out 011, 022, 033, 044 on the following 4 cycles, instr_valid continuously 1, running = 1, load_count = 4.
- Out-of-range fetch: after loading 4 words, fetch addresses 4 and 16'h0100 → instr_out = 000 with addr_fault = 1 and instr_valid = 1 on each response cycle; then fetch address 2 → 033 with addr_fault = 0.
- Overflow: DEPTH = 4; stream 6 load_valid words → load_count stops at 4 and load_overflow = 1; load_done then fetch address 3 → 4th word.
- Simultaneous load_valid and load_done with 9'h1FF as the 3rd word → load_count = 3; fetch address 2 returns 1FF.
- Gating before run: fetch_req asserted during IDLE and LOAD → instr_valid stays 0 throughout.
- Mid-operation disruption:
  - In RUN, assert load_start together with fetch_req → no valid next cycle, state LOAD, load_count = 0.
  - Separately, assert reset_ctrl mid-LOAD off a clock edge → outputs clear immediately; after re-entering RUN with no load, any fetch faults.
